carry_select_adder: RTL and testbench
=====================================

# carry_select_adder

32-bit two's-complement adder with carry-in, built as a carry-select structure of 4-bit ripple blocks, with registered sum, carry-out and signed-overflow outputs. It serves as the adder core in the arithmetic datapath. It gives fast carry resolution: each block precomputes both carry-in cases and a mux chain selects between them. Result, carry and overflow are captured on the clock so the block drops into a pipelined datapath.

## Interface
- No parameters; width fixed at 32 bits, block size fixed at 4 bits.
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  input  1  rising-edge clock for output registers.
- rst_n  input  1  synchronous active-low reset.
- a  input  32  addend A, two's complement.
- b  input  32  addend B, two's complement.
- Cin  input  1  carry-in, weight 1.
- S  output  32  registered sum, a + b + Cin mod 2^32.
- Cout  output  1  registered unsigned carry out of bit 31.
- Overflow  output  1  registered signed overflow flag.

## Operation
- Block 0 (bits 3:0) is a single 4-bit ripple-carry adder fed by Cin.
- Blocks 1..7 (bits 7:4 … 31:28) each contain two 4-bit ripple adders:
  - one with carry-in 0;
  - one with carry-in 1.
- Each block's sum and carry-out are selected by a 2:1 mux, controlled by the selected carry-out of the previous block.
- Full adder per bit:
  - s = a ^ b ^ c;
  - co = a&b | a&c | b&c.
- Combinational results:
  - sum_c = a + b + Cin, low 32 bits;
  - cout_c = bit 32 of that 33-bit sum;
  - ovf_c = c31 ^ c32, the carry into bit 31 XOR the carry out of bit 31.
- ovf_c equals (a[31]==b[31]) && (sum_c[31]!=a[31]). The block-7 selection must expose c31 for this purpose, taken from the selected bit-30 carry of the chosen adder.
- Register update on each rising clk:
  - if rst_n==0: S<=0, Cout<=0, Overflow<=0;
  - else: S<=sum_c, Cout<=cout_c, Overflow<=ovf_c.
- No enable and no handshake; a new operation is accepted every cycle.
- Boundary rules:
  - MAX_INT + 1 gives S=0x80000000, Cout=0, Overflow=1.
  - MIN_INT + (−1) gives S=0x7FFFFFFF, Cout=1, Overflow=1.
  - 0xFFFFFFFF + 0 + Cin=1 gives S=0, Cout=1, Overflow=0, with the carry propagating through all 8 blocks.
  - Mixed-sign operands never set Overflow.
- X-free: every output is defined from the first clock edge with rst_n low.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on S/Cout/Overflow after edge N; they are stable for the whole of cycle N+1.
- Throughput: 1 operation per cycle.
- Reset is synchronous and dominates: rst_n low at an edge zeroes all outputs regardless of a/b/Cin.
- Reset asserted mid-stream discards the in-flight result. The first valid result after release is from inputs sampled on the first edge with rst_n high.
- Combinational critical path: block-0 ripple (4 full adders), then 7 mux stages, then the overflow XOR. No path passes through more than one 4-bit ripple beyond block 0.
- Outputs change only on rising clk.

## Test plan
- Reset: hold rst_n=0 for 2 edges with a=0xFFFFFFFF, b=1, Cin=1 → S=0, Cout=0, Overflow=0. Then release and apply 8+7, Cin=0 → next edge S=15, Cout=0, Overflow=0.
- Signed overflow:
  - a=0x7FFFFFFF, b=1, Cin=0 → S=0x80000000, Cout=0, Overflow=1;
  - a=0x80000000, b=0xFFFFFFFF, Cin=0 → S=0x7FFFFFFF, Cout=1, Overflow=1.
- Mixed and negative operands:
  - 5 + (−3), Cin=0 → S=2, Cout=1, Overflow=0;
  - −10 + (−8) → S=−18 (0xFFFFFFEE), Cout=1, Overflow=0;
  - −30 + 40, Cin=1 → S=11, Cout=1, Overflow=0.
- Carry-in handling:
  - 100 + 50, Cin=1 → S=151, Cout=0, Overflow=0;
  - 0 + 0, Cin=1 → S=1, Cout=0, Overflow=0.
- Full carry chain: a=0xFFFFFFFF, b=0, Cin=1 → S=0, Cout=1, Overflow=0. Also a=0x0000000F, b=1 → S=0x10, which exercises the block-0→block-1 select.
- Pipeline and random check:
  - back-to-back distinct vectors every cycle, checking 1-cycle latency;
  - ≥10,000 random a/b/Cin compared against a 33-bit reference sum and the sign-rule overflow.

Source files
------------

// File: rtl/carry_select_adder.sv
// -----------------------------------------------------------------------------
// carry_select_adder
//
// 32-bit two's-complement adder with carry-in. The result is built from eight
// 4-bit blocks. Block 0 ripples from Cin. Every other block computes its sum
// twice, once for carry-in 0 and once for carry-in 1. The carry out of the
// previous block then picks one of the two results. The worst-case path is
// therefore one 4-bit ripple followed by seven 2:1 muxes, not a 32-bit ripple.
// Sum, carry-out and signed overflow are registered, so the result appears one
// cycle after the operands are sampled.
//
// Ports
//   clk       in   1   rising-edge clock for the output registers
//   rst_n     in   1   synchronous active-low reset; clears all outputs
//   a         in  32   addend A, two's complement
//   b         in  32   addend B, two's complement
//   Cin       in   1   carry-in, weight 1
//   S         out 32   registered sum, a + b + Cin mod 2^32
//   Cout      out  1   registered unsigned carry out of bit 31
//   Overflow  out  1   registered signed-overflow flag
// -----------------------------------------------------------------------------
module carry_select_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout,
    output logic        Overflow
);

    // blk_co[k] is the selected carry into block k. blk_co[8] is the carry
    // out of bit 31.
    logic [8:0]  blk_co;
    logic [31:0] sum_c;
    logic        c31;        // carry into bit 31, taken from block 7's selection
    logic        ovf_c;

    logic [31:0] s_q,    s_d;
    logic        cout_q, cout_d;
    logic        ovf_q,  ovf_d;

    assign blk_co[0] = Cin;

    // ---------------------------------------------------------------------
    // Block 0: a plain 4-bit ripple adder driven by Cin.
    // ---------------------------------------------------------------------
    logic [4:0] b0_c;
    assign b0_c[0] = blk_co[0];

    genvar gi, gj;
    generate
        for (gj = 0; gj < 4; gj++) begin : g_blk0_fa
            assign sum_c[gj]   = a[gj] ^ b[gj] ^ b0_c[gj];
            assign b0_c[gj+1]  = (a[gj] & b[gj]) | (a[gj] & b0_c[gj]) | (b[gj] & b0_c[gj]);
        end
    endgenerate

    assign blk_co[1] = b0_c[4];

    // ---------------------------------------------------------------------
    // Blocks 1..7: each block has two ripple adders, one for carry-in 0 and
    // one for carry-in 1. The carry from the previous block selects between
    // them.
    // ---------------------------------------------------------------------
    generate
        for (gi = 1; gi < 8; gi++) begin : g_blk
            logic [4:0] c0;      // ripple chain assuming carry-in 0
            logic [4:0] c1;      // ripple chain assuming carry-in 1
            logic [3:0] s0;
            logic [3:0] s1;

            assign c0[0] = 1'b0;
            assign c1[0] = 1'b1;

            for (gj = 0; gj < 4; gj++) begin : g_fa
                assign s0[gj]   = a[4*gi+gj] ^ b[4*gi+gj] ^ c0[gj];
                assign c0[gj+1] = (a[4*gi+gj] & b[4*gi+gj])
                                | (a[4*gi+gj] & c0[gj])
                                | (b[4*gi+gj] & c0[gj]);
                assign s1[gj]   = a[4*gi+gj] ^ b[4*gi+gj] ^ c1[gj];
                assign c1[gj+1] = (a[4*gi+gj] & b[4*gi+gj])
                                | (a[4*gi+gj] & c1[gj])
                                | (b[4*gi+gj] & c1[gj]);
            end

            assign sum_c[4*gi+3:4*gi] = blk_co[gi] ? s1    : s0;
            assign blk_co[gi+1]       = blk_co[gi] ? c1[4] : c0[4];

            // The top block also supplies the carry into bit 31, which is
            // needed for the overflow flag. It is selected the same way as
            // the block's carry-out.
            if (gi == 7) begin : g_c31
                assign c31 = blk_co[gi] ? c1[3] : c0[3];
            end
        end
    endgenerate

    // Signed overflow: the carry into the sign bit differs from the carry out.
    assign ovf_c = c31 ^ blk_co[8];

    // ---------------------------------------------------------------------
    // Output registers
    // ---------------------------------------------------------------------
    always_comb begin
        s_d    = sum_c;
        cout_d = blk_co[8];
        ovf_d  = ovf_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= 32'd0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign S        = s_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// -----------------------------------------------------------------------------
// tb_carry_select_adder
//
// The driver applies one vector per cycle on the falling edge. At the same
// time it pushes the expected registered response into a queue. The monitor
// runs on each rising edge where a vector was issued. It waits #1, pops the
// queue and compares the popped entry with S/Cout/Overflow.
// -----------------------------------------------------------------------------
module tb_carry_select_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        Cin;
    logic [31:0] S;
    logic        Cout;
    logic        Overflow;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    logic issue;
    int   n_vec;
    int   n_err;

    carry_select_adder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .Cin      (Cin),
        .S        (S),
        .Cout     (Cout),
        .Overflow (Overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one vector on the falling edge and record the response expected
    // after the next rising edge.
    task automatic apply(input logic rst, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic [31:0] es, input logic ec,
                         input logic ev);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        a     = av;
        b     = bv;
        Cin   = cv;
        issue = 1'b1;
        e.s = es;
        e.c = ec;
        e.v = ev;
        exp_q.push_back(e);
    endtask

    // Monitor: compare once per issued vector.
    initial begin
        logic pend;
        exp_t e;
        forever begin
            @(posedge clk);
            pend = issue;
            #1;
            if (pend) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL queue: response with empty scoreboard, got S=%h C=%b V=%b",
                             S, Cout, Overflow);
                end else begin
                    e = exp_q.pop_front();
                    if (S !== e.s || Cout !== e.c || Overflow !== e.v) begin
                        n_err++;
                        $display("FAIL vec%0d: got S=%h C=%b V=%b, want S=%h C=%b V=%b",
                                 n_vec, S, Cout, Overflow, e.s, e.c, e.v);
                    end else begin
                        $display("vec%0d ok: S=%h C=%b V=%b", n_vec, S, Cout, Overflow);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] full;
        logic        rv;
        int          waited;

        n_vec = 0;
        n_err = 0;
        issue = 1'b0;
        rst_n = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'd1;
        Cin   = 1'b1;

        // Reset is held for two edges with non-zero operands. The outputs
        // must stay zero.
        apply(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
        apply(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
        // Directed vectors, applied back-to-back.
        apply(1'b1, 32'h0000_0008, 32'h0000_0007, 1'b0, 32'h0000_000F, 1'b0, 1'b0);
        apply(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        apply(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        apply(1'b1, 32'h0000_0005, 32'hFFFF_FFFD, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
        apply(1'b1, 32'hFFFF_FFF6, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFEE, 1'b1, 1'b0);
        apply(1'b1, 32'hFFFF_FFE2, 32'h0000_0028, 1'b1, 32'h0000_000B, 1'b1, 1'b0);
        apply(1'b1, 32'h0000_0064, 32'h0000_0032, 1'b1, 32'h0000_0097, 1'b0, 1'b0);
        apply(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        apply(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        apply(1'b1, 32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
        apply(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        apply(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        // Reset in the middle of the stream discards that vector. The vector
        // after release is the first one that counts.
        apply(1'b0, 32'h1234_5678, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        apply(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);

        // Random vectors, checked against a 33-bit sum and the sign rule.
        for (int i = 0; i < 10000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            rv   = (ra[31] == rb[31]) && (full[31] != ra[31]);
            apply(1'b1, ra, rb, rc, full[31:0], full[32], rv);
        end

        @(negedge clk);
        issue = 1'b0;

        waited = 0;
        while (exp_q.size() != 0 && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected responses never checked", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
